mult_radix4_serial: RTL and testbench
=====================================

Name: mult_radix4_serial

Overview:
- Parametrised, multi-cycle successor to the fixed 4x4 split multiplier: WIDTH x WIDTH product built from 2x2-bit digit sub-products, retiring one 2-bit digit of B per clock into a shifted accumulator.
- Adds a valid/ready handshake on both sides, a per-transaction signed/unsigned mode, and back-to-back operation.
- Sits between operand sources and result consumers in the multiplier datapath; it is the template for scaling the 2-bit decomposition to 8/16/32 bits.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 4. N = WIDTH/2 = digit count.
- CNT_W, $clog2(WIDTH/2) (min 1), digit counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands presented
- in_ready  out  1  block can accept operands this cycle
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- A  in  WIDTH  multiplicand
- B  in  WIDTH  multiplier
- out_valid  out  1  P holds a finished product
- out_ready  in  1  consumer takes P this cycle
- P  out  2*WIDTH  product
- busy  out  1  high in RUN state

Behaviour:
- Reset: one clk edge with rst_n=0 forces state IDLE, out_valid=0, busy=0, P=0, accumulator=0, counter=0; in_ready=1 on the first cycle after reset release. Reset mid-RUN or in DONE discards the transaction with no output.
- States: IDLE, RUN, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready), combinational. Accept = in_valid & in_ready.
- On accept: latch magA = |A|, magB = |B| (WIDTH-bit unsigned magnitudes) and neg = is_signed & (A[WIDTH-1]^B[WIDTH-1]). When is_signed=0, magnitudes are the raw operands and neg=0. Clear the accumulator and counter j, then go to RUN.
- RUN, one edge per digit, j = 0..N-1: acc += (sum over i in 0..N-1 of pp(magA[2i+1:2i], magB[2j+1:2j]) << 2i) << 2j. pp is an exact 2x2 -> 4-bit product, and N pp instances are combinational. The accumulator is 2*WIDTH bits and never overflows.
- On the edge where j = N-1: P <= neg ? -(final acc) : final acc (two's complement, 2*WIDTH bits). Go to DONE with out_valid=1. j wraps to 0.
- Latency: out_valid rises exactly N clk edges after the accepting edge (4 for WIDTH=8). Throughput is one product per N+1 cycles with out_ready held high.
- DONE: P and out_valid are held stable while out_ready=0.
  - out_ready=1 and no new accept: go to IDLE, out_valid=0.
  - out_ready=1 with a simultaneous accept: go straight to RUN with the new operands, out_valid=0.
- in_valid, A, B and is_signed are ignored outside accept cycles. Changing them during RUN has no effect.
- Boundary: signed -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. (-2^(W-1))^2 = 2^(2W-2) fits in the signed 2*WIDTH result. A zero product with neg=1 yields 0, never negative zero.
- P holds its last value in IDLE; it is not cleared on handoff.

Test Plan:
- WIDTH=8, unsigned A=13, B=11, out_ready=1 -> out_valid 4 edges after accept, P=0x008F, then IDLE with in_ready=1.
- Unsigned A=255, B=255 -> P=0xFE01. Signed A=-128, B=-128 -> P=0x4000. Signed A=127, B=-128 -> P=0xC080. Signed A=-3, B=5 -> P=0xFFF1. Signed A=0, B=-7 -> P=0x0000.
- Backpressure: complete 13x11, hold out_ready=0 for 3 cycles with in_valid=1 -> P stays 0x008F, out_valid=1, in_ready=0, no accept. Raise out_ready -> same-cycle accept of the next operands, busy=1 next cycle.
- Back-to-back stream of 20 random signed/unsigned pairs with in_valid and out_ready always high -> every product matches the reference model, in order, one result every 5 cycles.
- Reset mid-op: rst_n=0 for one edge two cycles after accepting 200x200 -> out_valid=0, busy=0, P=0, in_ready=1. No stale result ever appears.
- Re-run the random regression with WIDTH=4 and WIDTH=16 -> exact match. Latency is 2 and 8 edges respectively.

Source files
------------

// File: rtl/mult_radix4_serial.sv
// mult_radix4_serial: WIDTH x WIDTH multiplier that decomposes both operands
// into 2-bit digits and retires one digit of the multiplier per clock.
// Signed operands are handled as sign-magnitude: magnitudes are multiplied
// unsigned and the product is negated once at the end when the signs differ.
// Valid/ready handshakes on both sides; a result handed off in DONE can be
// overlapped with the acceptance of the next operand pair.

module mult_radix4_serial #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int N      = WIDTH / 2;
    localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
    localparam int PW     = 2 * WIDTH;
    localparam int ROW_W  = WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Exact 2x2 -> 4-bit digit product.
    function automatic logic [3:0] digit_product(input logic [1:0] da, input logic [1:0] db);
        digit_product = {2'b00, da} * {2'b00, db};
    endfunction

    // Unsigned magnitude of an operand; -2^(WIDTH-1) maps to 2^(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = ~v + WIDTH'(1);
        end else begin
            magnitude = v;
        end
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [WIDTH-1:0]    mag_a_r;
    logic [WIDTH-1:0]    mag_b_r;
    logic                neg_r;
    logic [PW-1:0]       acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [PW-1:0]       p_r;
    logic                out_valid_r;
    logic                busy_r;

    logic                in_ready_s;
    logic                accept_s;
    logic                last_digit_s;
    logic [1:0]          digit_b_s;
    logic [ROW_W-1:0]    row_s;
    logic [PW-1:0]       row_shifted_s;
    logic [PW-1:0]       acc_nx_s;
    logic [PW-1:0]       result_s;

    // Handshake and next-state decode.
    always_comb begin
        in_ready_s   = 1'b0;
        accept_s     = 1'b0;
        state_nx_s   = state_r;
        last_digit_s = (cnt_r == LAST_DIGIT);
        if ((state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s = in_valid & in_ready_s;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_digit_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (!out_ready) begin
                    state_nx_s = ST_DONE;
                end else if (accept_s) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // One partial-product row: magA times the current multiplier digit,
    // built from N digit products, then aligned to the digit position.
    always_comb begin
        digit_b_s = mag_b_r[{cnt_r, 1'b0} +: 2];
        row_s     = '0;
        for (int i = 0; i < N; i++) begin
            row_s = row_s + (ROW_W'(digit_product(mag_a_r[2*i +: 2], digit_b_s)) << (2*i));
        end
        row_shifted_s = {{(PW-ROW_W){1'b0}}, row_s} << {cnt_r, 1'b0};
        acc_nx_s      = acc_r + row_shifted_s;
        if (neg_r) begin
            result_s = ~acc_nx_s + PW'(1);
        end else begin
            result_s = acc_nx_s;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Operand capture, digit accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mag_a_r     <= '0;
            mag_b_r     <= '0;
            neg_r       <= 1'b0;
            acc_r       <= '0;
            cnt_r       <= '0;
            p_r         <= '0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        mag_a_r <= magnitude(A, is_signed);
                        mag_b_r <= magnitude(B, is_signed);
                        neg_r   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc_r   <= '0;
                        cnt_r   <= '0;
                    end else begin
                        acc_r   <= acc_r;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nx_s;
                    if (last_digit_s) begin
                        cnt_r <= '0;
                        p_r   <= result_s;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    acc_r <= '0;
                    cnt_r <= '0;
                end
            endcase
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s == ST_RUN);
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign P         = p_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_mult_radix4_serial.sv
// Bench for mult_radix4_serial: three instances (WIDTH 4, 8, 16) sharing
// clock and reset. Directed vectors with hand-computed products, handshake
// and reset scenarios on WIDTH=8, and short back-to-back streams per width
// checked against an integer reference product.

module tb_mult_radix4_serial;

    logic clk = 1'b0;
    logic rst_n;

    logic iv4, sg4, or4, ir4, ov4, bz4;
    logic [3:0] a4, b4;
    logic [7:0] p4;
    logic iv8, sg8, or8, ir8, ov8, bz8;
    logic [7:0] a8, b8;
    logic [15:0] p8;
    logic iv16, sg16, or16, ir16, ov16, bz16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mult_radix4_serial #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .is_signed(sg4),
        .A(a4), .B(b4), .out_valid(ov4), .out_ready(or4), .P(p4), .busy(bz4));
    mult_radix4_serial #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .is_signed(sg8),
        .A(a8), .B(b8), .out_valid(ov8), .out_ready(or8), .P(p8), .busy(bz8));
    mult_radix4_serial #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .is_signed(sg16),
        .A(a16), .B(b16), .out_valid(ov16), .out_ready(or16), .P(p16), .busy(bz16));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // unit 0 = WIDTH 4, 1 = WIDTH 8, 2 = WIDTH 16
    function automatic int width_of(input int u);
        case (u)
            0: width_of = 4;
            1: width_of = 8;
            default: width_of = 16;
        endcase
    endfunction

    task automatic drive(input int u, input logic v, input logic s,
                         input logic [15:0] a, input logic [15:0] b);
        case (u)
            0: begin iv4 = v; sg4 = s; a4 = a[3:0]; b4 = b[3:0]; end
            1: begin iv8 = v; sg8 = s; a8 = a[7:0]; b8 = b[7:0]; end
            default: begin iv16 = v; sg16 = s; a16 = a; b16 = b; end
        endcase
    endtask

    function automatic logic [31:0] p_of(input int u);
        case (u)
            0: p_of = {24'd0, p4};
            1: p_of = {16'd0, p8};
            default: p_of = p16;
        endcase
    endfunction

    function automatic logic ov_of(input int u);
        case (u)
            0: ov_of = ov4;
            1: ov_of = ov8;
            default: ov_of = ov16;
        endcase
    endfunction

    function automatic logic ir_of(input int u);
        case (u)
            0: ir_of = ir4;
            1: ir_of = ir8;
            default: ir_of = ir16;
        endcase
    endfunction

    // Reference product: plain integer multiply, truncated to 2*w bits.
    function automatic logic [31:0] model(input int u, input logic s,
                                          input logic [15:0] a, input logic [15:0] b);
        int w;
        longint ia, ib, prod, mask;
        w  = width_of(u);
        ia = longint'(a);
        ib = longint'(b);
        if (s && a[w-1]) ia = ia - (longint'(1) << w);
        if (s && b[w-1]) ib = ib - (longint'(1) << w);
        prod = ia * ib;
        mask = (longint'(1) << (2*w)) - longint'(1);
        model = 32'(prod & mask);
    endfunction

    // Single transaction from IDLE with out_ready high: checks latency, P, return to IDLE.
    task automatic run_op(input int u, input logic s, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp, input string tag);
        int lat;
        chk({tag, " in_ready"}, 32'(ir_of(u)), 32'd1);
        drive(u, 1'b1, s, a, b);
        step;
        drive(u, 1'b0, s, a, b);
        lat = 0;
        while (!ov_of(u) && lat < 64) begin
            step;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(width_of(u) / 2));
        chk({tag, " P"}, p_of(u), exp);
        step;
        chk({tag, " back to idle"}, 32'({ir_of(u), ov_of(u)}), 32'b10);
    endtask

    // Back-to-back random stream with in_valid and out_ready held high.
    task automatic stream(input int u, input int n);
        logic [15:0] ra[20];
        logic [15:0] rb[20];
        logic        rs[20];
        logic [15:0] mask;
        int lat;
        mask = 16'((32'd1 << width_of(u)) - 32'd1);
        for (int k = 0; k < n; k++) begin
            ra[k] = 16'($urandom) & mask;
            rb[k] = 16'($urandom) & mask;
            rs[k] = 1'($urandom_range(0, 1));
        end
        drive(u, 1'b1, rs[0], ra[0], rb[0]);
        step;
        for (int k = 0; k < n; k++) begin
            if (k < n - 1) begin
                drive(u, 1'b1, rs[k+1], ra[k+1], rb[k+1]);
            end else begin
                drive(u, 1'b0, 1'b0, 16'd0, 16'd0);
            end
            lat = 0;
            while (!ov_of(u) && lat < 64) begin
                step;
                lat++;
            end
            chk($sformatf("stream w%0d #%0d latency", width_of(u), k), 32'(lat), 32'(width_of(u) / 2));
            chk($sformatf("stream w%0d #%0d P", width_of(u), k), p_of(u), model(u, rs[k], ra[k], rb[k]));
            step;
        end
    endtask

    initial begin
        int stale;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(2, 1'b0, 1'b0, 16'd0, 16'd0);
        or4 = 1'b1; or8 = 1'b1; or16 = 1'b1;
        step;
        step;
        rst_n = 1'b1;
        chk("reset out_valid", 32'(ov8), 32'd0);
        chk("reset busy", 32'(bz8), 32'd0);
        chk("reset P", 32'(p8), 32'd0);
        chk("reset in_ready", 32'(ir8), 32'd1);

        // WIDTH=8 directed vectors
        run_op(1, 1'b0, 16'd13,   16'd11,   32'h008F, "u 13x11");
        run_op(1, 1'b0, 16'd255,  16'd255,  32'hFE01, "u 255x255");
        run_op(1, 1'b1, 16'h0080, 16'h0080, 32'h4000, "s -128x-128");
        run_op(1, 1'b1, 16'h007F, 16'h0080, 32'hC080, "s 127x-128");
        run_op(1, 1'b1, 16'h00FD, 16'h0005, 32'hFFF1, "s -3x5");
        run_op(1, 1'b1, 16'h0000, 16'h00F9, 32'h0000, "s 0x-7");

        // Backpressure: result held, no accept while out_ready low
        or8 = 1'b0;
        drive(1, 1'b1, 1'b0, 16'd13, 16'd11);
        step;
        drive(1, 1'b1, 1'b0, 16'd7, 16'd9);
        repeat (4) step;
        chk("bp done out_valid", 32'(ov8), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step;
            chk($sformatf("bp hold %0d P", k), 32'(p8), 32'h008F);
            chk($sformatf("bp hold %0d valid/ready", k), 32'({ov8, ir8}), 32'b10);
        end
        or8 = 1'b1;
        #1;
        chk("bp release in_ready", 32'(ir8), 32'd1);
        step;
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
        chk("bp next busy", 32'({bz8, ov8}), 32'b10);
        repeat (4) step;
        chk("bp next P", 32'({ov8, p8}), {15'd0, 1'b1, 16'h003F});
        step;

        // Reset in the middle of a transaction
        drive(1, 1'b1, 1'b0, 16'd200, 16'd200);
        step;
        drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
        step;
        step;
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        chk("midrst out_valid", 32'(ov8), 32'd0);
        chk("midrst busy", 32'(bz8), 32'd0);
        chk("midrst P", 32'(p8), 32'd0);
        chk("midrst in_ready", 32'(ir8), 32'd1);
        stale = 0;
        repeat (8) begin
            step;
            if (ov8) stale++;
        end
        chk("midrst no stale result", 32'(stale), 32'd0);

        // Back-to-back streams
        stream(1, 20);
        stream(0, 20);
        stream(2, 20);

        // WIDTH=4 and WIDTH=16 directed vectors
        run_op(0, 1'b0, 16'd15,   16'd15,   32'h000000E1, "w4 u 15x15");
        run_op(0, 1'b1, 16'h0008, 16'h0008, 32'h00000040, "w4 s -8x-8");
        run_op(0, 1'b1, 16'h0007, 16'h0008, 32'h000000C8, "w4 s 7x-8");
        run_op(0, 1'b1, 16'h000D, 16'h0005, 32'h000000F1, "w4 s -3x5");
        run_op(2, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16 u max");
        run_op(2, 1'b1, 16'h8000, 16'h8000, 32'h40000000, "w16 s min^2");
        run_op(2, 1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, "w16 s -3x5");
        run_op(2, 1'b0, 16'd1234, 16'd5678, 32'h006AE9BC, "w16 u 1234x5678");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
